// File: rtl/up_pkg.sv
// Shared constants and control-word layout for the 4-bit processing unit.
package up_pkg;

  localparam logic [3:0] G_TA   = 4'b0000;
  localparam logic [3:0] G_INC  = 4'b0001;
  localparam logic [3:0] G_ADD  = 4'b0010;
  localparam logic [3:0] G_ADDC = 4'b0011;
  localparam logic [3:0] G_ADNB = 4'b0100;
  localparam logic [3:0] G_SUB  = 4'b0101;
  localparam logic [3:0] G_DEC  = 4'b0110;
  localparam logic [3:0] G_TA2  = 4'b0111;
  localparam logic [3:0] G_AND  = 4'b1000;
  localparam logic [3:0] G_OR   = 4'b1010;
  localparam logic [3:0] G_XOR  = 4'b1100;
  localparam logic [3:0] G_NOT  = 4'b1110;

  localparam logic [1:0] H_PASS = 2'b00;
  localparam logic [1:0] H_SHR  = 2'b01;
  localparam logic [1:0] H_SHL  = 2'b10;
  localparam logic [1:0] H_ZERO = 2'b11;

  localparam int CW_A    = 14;
  localparam int CW_B    = 12;
  localparam int CW_DEST = 10;
  localparam int CW_WE   = 9;
  localparam int CW_MB   = 8;
  localparam int CW_G    = 4;
  localparam int CW_H    = 2;
  localparam int CW_MF   = 1;
  localparam int CW_MD   = 0;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] dest;
    logic       we;
    logic       mb;
    logic [3:0] g;
    logic [1:0] h;
    logic       mf;
    logic       md;
  } ctrl_t;

endpackage

// File: rtl/up_alu.sv
// Combinational 4-bit ALU: arithmetic through one adder, logic ops clear C/V.
module up_alu
  import up_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] g_i,
  output logic [3:0] f_o,
  output logic       v_o,
  output logic       n_o,
  output logic       z_o,
  output logic       c_o
);

  logic [3:0] y;
  logic [4:0] sum;

  // Arithmetic ops are A + Y + G[0], with Y picked by G[2:1]
  always_comb begin
    y = 4'h0;
    unique case (g_i[2:1])
      2'b00: y = 4'h0;
      2'b01: y = b_i;
      2'b10: y = ~b_i;
      2'b11: y = 4'hF;
      default: y = 4'h0;
    endcase
    sum = {1'b0, a_i} + {1'b0, y} + {4'b0, g_i[0]};
  end

  always_comb begin
    f_o = sum[3:0];
    c_o = sum[4];
    v_o = (a_i[3] == y[3]) && (sum[3] != a_i[3]);
    if (g_i[3]) begin
      c_o = 1'b0;
      v_o = 1'b0;
      unique case (g_i[2:1])
        G_AND[2:1]: f_o = a_i & b_i;
        G_OR[2:1]:  f_o = a_i | b_i;
        G_XOR[2:1]: f_o = a_i ^ b_i;
        G_NOT[2:1]: f_o = ~a_i;
        default:    f_o = 4'h0;
      endcase
    end
    n_o = f_o[3];
    z_o = (f_o == 4'h0);
  end

endmodule

// File: rtl/unidad_procesadora_4b.sv
// 4-bit datapath: register file, ALU/shifter function unit, flags register.
module unidad_procesadora_4b
  import up_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] control,
  input  logic [3:0]  datain,
  output logic [3:0]  flags,
  output logic [3:0]  dataout,
  output logic [3:0]  adr_out
);

  ctrl_t      c;
  logic [3:0] rf_q [4];
  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [3:0] bus_a;
  logic [3:0] bus_b;
  logic [3:0] alu_f;
  logic [3:0] sh_f;
  logic [3:0] fn;
  logic [3:0] wb;
  logic       alu_v;
  logic       alu_n;
  logic       alu_z;
  logic       alu_c;

  assign c     = ctrl_t'(control);
  assign bus_a = rf_q[c.a];
  assign bus_b = c.mb ? datain : rf_q[c.b];

  up_alu u_alu (
    .a_i (bus_a),
    .b_i (bus_b),
    .g_i (c.g),
    .f_o (alu_f),
    .v_o (alu_v),
    .n_o (alu_n),
    .z_o (alu_z),
    .c_o (alu_c)
  );

  always_comb begin
    sh_f = 4'h0;
    unique case (c.h)
      H_PASS: sh_f = bus_b;
      H_SHR:  sh_f = bus_b >> 1;
      H_SHL:  sh_f = bus_b << 1;
      H_ZERO: sh_f = 4'h0;
      default: sh_f = 4'h0;
    endcase
  end

  assign fn = c.mf ? sh_f : alu_f;
  assign wb = c.md ? datain : fn;

  // Flags track the ALU whenever it drives F, regardless of write-back
  always_comb begin
    flags_d = flags_q;
    if (!c.mf) begin
      flags_d[FLAG_V] = alu_v;
      flags_d[FLAG_N] = alu_n;
      flags_d[FLAG_Z] = alu_z;
      flags_d[FLAG_C] = alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= 4'h0;
      flags_q <= 4'h0;
    end else begin
      if (c.we) rf_q[c.dest] <= wb;
      flags_q <= flags_d;
    end
  end

  assign flags   = flags_q;
  assign dataout = rf_q[c.b];
  assign adr_out = rf_q[c.a];

endmodule

// File: tb/tb_unidad_procesadora_4b.sv
// Directed vector bench for the 4-bit processing unit.
module tb_unidad_procesadora_4b;

  logic        clk;
  logic        reset;
  logic [15:0] control;
  logic [3:0]  datain;
  logic [3:0]  flags;
  logic [3:0]  dataout;
  logic [3:0]  adr_out;

  int n_applied;
  int n_miss;

  typedef struct {
    logic [15:0] ctrl;
    logic [3:0]  din;
    logic [3:0]  fl;
    logic [3:0]  dout;
    logic [3:0]  adr;
  } vec_t;

  vec_t vecs [21];

  unidad_procesadora_4b dut (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .datain  (datain),
    .flags   (flags),
    .dataout (dataout),
    .adr_out (adr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cw(
    input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
    input logic we, input logic mb, input logic [3:0] g,
    input logic [1:0] h, input logic mf, input logic md);
    return {a, b, d, we, mb, g, h, mf, md};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [3:0] fl,
                           input logic [3:0] dout, input logic [3:0] adr);
    n_applied++;
    chk("flags", idx, flags, fl);
    chk("dataout", idx, dataout, dout);
    chk("adr_out", idx, adr_out, adr);
  endtask

  initial begin
    n_applied = 0;
    n_miss    = 0;

    vecs[0]  = '{cw(1,1,1,1,0,4'b0000,2'b00,1,1), 4'h5, 4'h0, 4'h5, 4'h5};
    vecs[1]  = '{cw(0,0,0,1,0,4'b0000,2'b00,1,1), 4'hF, 4'h0, 4'hF, 4'hF};
    vecs[2]  = '{cw(2,1,2,1,0,4'b0000,2'b00,1,1), 4'h3, 4'h0, 4'h5, 4'h3};
    vecs[3]  = '{cw(3,2,3,1,0,4'b0000,2'b00,1,1), 4'h9, 4'h0, 4'h3, 4'h9};
    vecs[4]  = '{cw(1,2,3,1,0,4'b0010,2'b00,0,0), 4'h0, 4'hC, 4'h3, 4'h5};
    vecs[5]  = '{cw(3,1,0,0,0,4'b0101,2'b00,0,0), 4'h0, 4'h9, 4'h5, 4'h8};
    vecs[6]  = '{cw(1,1,2,1,0,4'b0101,2'b00,0,0), 4'h0, 4'h3, 4'h5, 4'h5};
    vecs[7]  = '{cw(0,0,0,1,0,4'b0001,2'b00,0,0), 4'h0, 4'h3, 4'h0, 4'h0};
    vecs[8]  = '{cw(1,1,2,1,1,4'b0010,2'b00,0,0), 4'h2, 4'h0, 4'h5, 4'h5};
    vecs[9]  = '{cw(1,2,0,0,0,4'b0010,2'b00,0,0), 4'h0, 4'hC, 4'h7, 4'h5};
    vecs[10] = '{cw(3,1,3,1,0,4'b0000,2'b10,1,0), 4'h0, 4'hC, 4'h5, 4'hA};
    vecs[11] = '{cw(3,1,3,1,0,4'b0000,2'b01,1,0), 4'h0, 4'hC, 4'h5, 4'h2};
    vecs[12] = '{cw(3,1,3,1,0,4'b0000,2'b11,1,0), 4'h0, 4'hC, 4'h5, 4'h0};
    vecs[13] = '{cw(1,2,0,0,0,4'b1101,2'b00,0,0), 4'h0, 4'h0, 4'h7, 4'h5};
    vecs[14] = '{cw(3,0,0,1,0,4'b1110,2'b00,0,0), 4'h0, 4'h4, 4'hF, 4'h0};
    vecs[15] = '{cw(2,0,0,0,0,4'b0110,2'b00,0,0), 4'h0, 4'h1, 4'hF, 4'h7};
    vecs[16] = '{cw(0,1,1,1,0,4'b0000,2'b00,0,1), 4'hA, 4'h4, 4'hA, 4'hF};
    vecs[17] = '{cw(0,1,2,1,1,4'b0000,2'b10,1,0), 4'h3, 4'h4, 4'hA, 4'hF};
    vecs[18] = '{cw(2,2,0,0,0,4'b0000,2'b00,1,0), 4'h0, 4'h4, 4'h6, 4'h6};
    vecs[19] = '{cw(2,0,0,0,0,4'b0101,2'b00,0,0), 4'h0, 4'h0, 4'hF, 4'h6};
    vecs[20] = '{cw(0,2,0,0,0,4'b0100,2'b00,0,0), 4'h0, 4'h5, 4'h6, 4'hF};

    // Reset with a write and flag load requested: reset must win
    reset   = 1'b1;
    control = cw(0,0,0,1,0,4'b0001,2'b00,0,1);
    datain  = 4'hF;
    @(posedge clk);
    #1;
    check_all(-1, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      control = vecs[i].ctrl;
      datain  = vecs[i].din;
      @(posedge clk);
      #1;
      check_all(i, vecs[i].fl, vecs[i].dout, vecs[i].adr);
    end

    // Mid-run reset clears non-zero registers and flags
    reset   = 1'b1;
    control = cw(1,2,3,1,0,4'b0010,2'b00,0,0);
    datain  = 4'h0;
    @(posedge clk);
    #1;
    check_all(100, 4'h0, 4'h0, 4'h0);
    reset   = 1'b0;
    control = cw(0,3,0,0,0,4'b0000,2'b00,1,0);
    @(posedge clk);
    #1;
    check_all(101, 4'h0, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
